// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - PLL run-time reconfiguration sequencer over the Avalon-MM mgmt port
`timescale 1ns/1ps
module pll_reconfig_seq #(
    parameter int LOCK_TIMEOUT = 1048575,
    parameter int POLL_LIMIT   = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c0,
    input  logic [31:0] cfg_k,
    input  logic        cfg_k_en,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam logic [20:0] LOCK_LIM = 21'(LOCK_TIMEOUT);
    localparam logic [12:0] POLL_LIM = 13'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C, WR_K, WR_START, POLL, WAIT_LOCK, DONE, FAIL
    } state_t;

    state_t      state_q, state_d, wr_next;
    logic        gap_q, gap_d;
    logic        is_wr;
    logic [11:0] poll_cnt_q, poll_cnt_d;
    logic [19:0] lock_cnt_q, lock_cnt_d;
    logic        error_q, error_d;
    logic        load_cfg;
    logic [17:0] n_q, m_q, c0_q;
    logic [31:0] k_q;
    logic        k_en_q;
    logic [1:0]  lock_sync_q;
    logic        unused_rdata;

    // Only the completion bit of the status register is meaningful
    assign unused_rdata = ^mgmt_readdata[31:1];

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign error = error_q;

    // FSM state, transfer phase, counters and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gap_q      <= 1'b0;
            poll_cnt_q <= '0;
            lock_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            poll_cnt_q <= poll_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            error_q    <= error_d;
        end
    end

    // Counter set captured at acceptance so the inputs may change mid-sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q    <= '0;
            m_q    <= '0;
            c0_q   <= '0;
            k_q    <= '0;
            k_en_q <= 1'b0;
        end else if (load_cfg) begin
            n_q    <= cfg_n;
            m_q    <= cfg_m;
            c0_q   <= cfg_c0;
            k_q    <= cfg_k;
            k_en_q <= cfg_k_en;
        end
    end

    // Two-flop synchroniser for the asynchronous lock indicator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked};
        end
    end

    // Next state and bus outputs; gap_q marks the idle cycle after each completed transfer
    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        poll_cnt_d     = poll_cnt_q;
        lock_cnt_d     = lock_cnt_q;
        error_d        = error_q;
        load_cfg       = 1'b0;
        is_wr          = 1'b0;
        wr_next        = IDLE;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        mgmt_write     = 1'b0;
        mgmt_read      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    load_cfg = 1'b1;
                    error_d  = 1'b0;
                    gap_d    = 1'b0;
                    state_d  = WR_MODE;
                end
            end
            WR_MODE: begin
                is_wr = 1'b1; wr_next = WR_N;
                mgmt_address = 6'd0; mgmt_writedata = 32'd1;
            end
            WR_N: begin
                is_wr = 1'b1; wr_next = WR_M;
                mgmt_address = 6'd3; mgmt_writedata = {14'b0, n_q};
            end
            WR_M: begin
                is_wr = 1'b1; wr_next = WR_C;
                mgmt_address = 6'd4; mgmt_writedata = {14'b0, m_q};
            end
            WR_C: begin
                is_wr = 1'b1; wr_next = k_en_q ? WR_K : WR_START;
                mgmt_address = 6'd5; mgmt_writedata = {9'b0, 5'd0, c0_q};
            end
            WR_K: begin
                is_wr = 1'b1; wr_next = WR_START;
                mgmt_address = 6'd7; mgmt_writedata = k_q;
            end
            WR_START: begin
                is_wr = 1'b1; wr_next = POLL;
                mgmt_address = 6'd2; mgmt_writedata = 32'd0;
            end
            POLL: begin
                mgmt_address = 6'd1;
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    mgmt_read = 1'b1;
                    if (!mgmt_waitrequest) begin
                        if (mgmt_readdata[0]) begin
                            state_d    = WAIT_LOCK;
                            lock_cnt_d = '0;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 12'd1;
                            if ({1'b0, poll_cnt_q} + 13'd1 >= POLL_LIM) begin
                                state_d = FAIL;
                                error_d = 1'b1;
                            end else begin
                                gap_d = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_LOCK: begin
                if (lock_sync_q[1]) begin
                    state_d = DONE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 20'd1;
                    if ({1'b0, lock_cnt_q} + 21'd1 >= LOCK_LIM) begin
                        state_d = FAIL;
                        error_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (is_wr) begin
            if (gap_q) begin
                gap_d   = 1'b0;
                state_d = wr_next;
                if (wr_next == POLL) begin
                    poll_cnt_d = '0;
                end
            end else begin
                mgmt_write = 1'b1;
                if (!mgmt_waitrequest) begin
                    gap_d = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb/tb_pll_reconfig_seq.sv - self-checking bench for pll_reconfig_seq
`timescale 1ns/1ps
module tb_pll_reconfig_seq;

    localparam int TB_LOCK = 16;
    localparam int TB_POLL = 8;
    localparam int MAX_CYC = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [17:0] cfg_n = '0;
    logic [17:0] cfg_m = '0;
    logic [17:0] cfg_c0 = '0;
    logic [31:0] cfg_k = '0;
    logic        cfg_k_en = 1'b0;
    logic        busy, done, error;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = 32'hFFFF_FFFE;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    int   cur_wait = 0;
    int   cur_ready = 0;
    int   cur_delay = -1;
    logic lock_pre = 1'b0;
    int   test_id = 0;

    bit [5:0]  exp_addr[$];
    bit        exp_we[$];
    bit [31:0] exp_data[$];
    int        log_addr[$];

    int   seen_id = 0, exp_idx = 0, reads_done = 0, lock_timer = 0;
    int   wl_cycles = 0, done_cnt = 0, xfer_cnt = 0, wcnt = 0, stb_len = 0;
    bit   after_poll = 0, lock_fired = 0;
    logic prev_stb = 0, prev_wait = 0, prev_we = 0, prev_rd = 0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic stb, rdy;

    pll_reconfig_seq #(.LOCK_TIMEOUT(TB_LOCK), .POLL_LIMIT(TB_POLL)) dut (
        .clk(clk), .rst(rst), .req(req),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_k(cfg_k), .cfg_k_en(cfg_k_en),
        .busy(busy), .done(done), .error(error),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input bit [5:0] a, input bit w, input bit [31:0] d);
        exp_addr.push_back(a);
        exp_we.push_back(w);
        exp_data.push_back(d);
    endtask

    // Avalon slave, lock source and per-cycle scoreboard, all sampled on the falling edge
    always @(negedge clk) begin
        if (test_id != seen_id) begin
            seen_id = test_id; exp_idx = 0; reads_done = 0; lock_timer = 0;
            after_poll = 0; lock_fired = 0; wl_cycles = 0; done_cnt = 0; xfer_cnt = 0;
            log_addr.delete();
        end
        if (!rst) begin
            chk("one_strobe", {63'b0, mgmt_write & mgmt_read}, 64'd0);
            if (done) done_cnt++;
            if (prev_stb && prev_wait) begin
                chk("hold_addr", {58'b0, mgmt_address}, {58'b0, prev_addr});
                chk("hold_data", {32'b0, mgmt_writedata}, {32'b0, prev_data});
                chk("hold_write", {63'b0, mgmt_write}, {63'b0, prev_we});
                chk("hold_read", {63'b0, mgmt_read}, {63'b0, prev_rd});
            end
            if (after_poll && busy && !done && !error) wl_cycles++;
            if (lock_timer > 0) begin
                lock_timer--;
                if (lock_timer == 0) lock_fired = 1;
            end
        end
        mgmt_waitrequest = 1'b0;
        mgmt_readdata    = 32'hFFFF_FFFE;
        stb = !rst && (mgmt_write || mgmt_read);
        if (stb) begin
            stb_len++;
            if (wcnt < cur_wait) begin
                mgmt_waitrequest = 1'b1;
                wcnt++;
            end else begin
                xfer_cnt++;
                log_addr.push_back(int'(mgmt_address));
                chk("strobe_cycles", 64'(stb_len), 64'(cur_wait + 1));
                if (exp_idx >= exp_addr.size()) begin
                    chk("extra_xfer", 64'(exp_idx), 64'(exp_addr.size()));
                end else begin
                    chk("xfer_addr", {58'b0, mgmt_address}, {58'b0, exp_addr[exp_idx]});
                    chk("xfer_dir", {63'b0, mgmt_write}, {63'b0, exp_we[exp_idx]});
                    if (exp_we[exp_idx])
                        chk("xfer_data", {32'b0, mgmt_writedata}, {32'b0, exp_data[exp_idx]});
                    exp_idx++;
                end
                if (mgmt_read) begin
                    rdy = (cur_ready >= 0) && (reads_done >= cur_ready);
                    mgmt_readdata = rdy ? 32'h0000_0001 : 32'hFFFF_FFFE;
                    reads_done++;
                    if (rdy) begin
                        after_poll = 1;
                        if (cur_delay == 0) lock_fired = 1;
                        else if (cur_delay > 0) lock_timer = cur_delay;
                    end
                end
                wcnt = 0;
                stb_len = 0;
            end
        end else begin
            wcnt = 0;
            stb_len = 0;
        end
        prev_stb  = stb;
        prev_wait = mgmt_waitrequest;
        prev_addr = mgmt_address;
        prev_data = mgmt_writedata;
        prev_we   = mgmt_write;
        prev_rd   = mgmt_read;
        pll_locked = lock_pre | lock_fired;
    end

    // Build the expected transfer list and outcome, launch one request, then judge the run
    task automatic run_seq(input string tag, input logic [17:0] n, input logic [17:0] m,
                           input logic [17:0] c0, input logic [31:0] k, input logic k_en,
                           input int wait_n, input int ready_after, input int lock_delay,
                           input logic pre_lock, input bit busy_req, input bit check_lat);
        bit poll_ok, ok;
        int exp_wl, n_reads, cyc, done_at;
        @(posedge clk); #1;
        cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_k = k; cfg_k_en = k_en;
        cur_wait = wait_n; cur_ready = ready_after; cur_delay = lock_delay; lock_pre = pre_lock;
        poll_ok = (ready_after >= 0) && (ready_after < TB_POLL);
        n_reads = poll_ok ? ready_after + 1 : TB_POLL;
        exp_wl = 0;
        if (!poll_ok) ok = 0;
        else if (pre_lock) begin exp_wl = 1; ok = 1; end
        else if (lock_delay < 0) begin exp_wl = TB_LOCK; ok = 0; end
        else begin
            exp_wl = lock_delay + 2;
            ok = 1;
            if (exp_wl > TB_LOCK) begin exp_wl = TB_LOCK; ok = 0; end
        end
        exp_addr.delete(); exp_we.delete(); exp_data.delete();
        push(6'd0, 1'b1, 32'd1);
        push(6'd3, 1'b1, {14'b0, n});
        push(6'd4, 1'b1, {14'b0, m});
        push(6'd5, 1'b1, {9'b0, 5'd0, c0});
        if (k_en) push(6'd7, 1'b1, k);
        push(6'd2, 1'b1, 32'd0);
        for (int i = 0; i < n_reads; i++) push(6'd1, 1'b0, 32'd0);
        test_id++;
        @(negedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk({tag, ":busy_after_req"}, {63'b0, busy}, 64'd1);
        chk({tag, ":error_cleared"}, {63'b0, error}, 64'd0);
        cyc = 1;
        done_at = -1;
        while (busy && cyc < MAX_CYC) begin
            if (done && done_at < 0) done_at = cyc;
            if (busy_req && (cyc == 5 || cyc == 9)) req = 1'b1;
            else req = 1'b0;
            @(negedge clk);
            cyc++;
        end
        req = 1'b0;
        chk({tag, ":finished_in_time"}, {63'b0, (cyc < MAX_CYC)}, 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, ":done_count"}, 64'(done_cnt), ok ? 64'd1 : 64'd0);
        chk({tag, ":error"}, {63'b0, error}, ok ? 64'd0 : 64'd1);
        chk({tag, ":busy_idle"}, {63'b0, busy}, 64'd0);
        chk({tag, ":xfer_count"}, 64'(xfer_cnt), 64'(exp_addr.size()));
        chk({tag, ":reads"}, 64'(reads_done), 64'(n_reads));
        if (poll_ok) chk({tag, ":wait_lock_cycles"}, 64'(wl_cycles), 64'(exp_wl));
        if (check_lat) chk({tag, ":latency_le_20"}, {63'b0, (done_at > 0 && done_at <= 20)}, 64'd1);
    endtask

    task automatic reset_mid;
        int cyc;
        @(posedge clk); #1;
        cur_wait = 0; cur_ready = 0; cur_delay = 3; lock_pre = 1'b0; cfg_k_en = 1'b1;
        exp_addr.delete(); exp_we.delete(); exp_data.delete();
        test_id++;
        @(negedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!(mgmt_write && mgmt_address == 6'd4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid:reached_wr_m", {63'b0, (cyc < 100)}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid:write_drop", {63'b0, mgmt_write}, 64'd0);
        chk("rst_mid:read_drop", {63'b0, mgmt_read}, 64'd0);
        chk("rst_mid:busy_drop", {63'b0, busy}, 64'd0);
        @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid:idle", {63'b0, busy}, 64'd0);
        chk("rst_mid:no_done", 64'(done_cnt), 64'd0);
        chk("rst_mid:no_error", {63'b0, error}, 64'd0);
    endtask

    int lit_nom[7]  = '{0, 3, 4, 5, 7, 2, 1};
    int lit_skip[6] = '{0, 3, 4, 5, 2, 1};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset:busy", {63'b0, busy}, 64'd0);
        chk("reset:write", {63'b0, mgmt_write}, 64'd0);
        chk("reset:read", {63'b0, mgmt_read}, 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset:busy", {63'b0, busy}, 64'd0);
        chk("post_reset:done", {63'b0, done}, 64'd0);
        chk("post_reset:error", {63'b0, error}, 64'd0);
        chk("post_reset:address", {58'b0, mgmt_address}, 64'd0);
        chk("post_reset:writedata", {32'b0, mgmt_writedata}, 64'd0);

        run_seq("nominal", 18'h30A05, 18'h12010, 18'h00402, 32'h8000_1234, 1'b1, 0, 0, 3, 1'b0, 0, 0);
        chk("nominal:lit_count", 64'(log_addr.size()), 64'd7);
        for (int i = 0; i < 7 && i < log_addr.size(); i++)
            chk("nominal:lit_addr", 64'(log_addr[i]), 64'(lit_nom[i]));
        chk("nominal:lit_wl", 64'(wl_cycles), 64'd5);

        run_seq("latency", 18'h00101, 18'h20303, 18'h10202, 32'hDEAD_BEEF, 1'b1, 0, 0, -1, 1'b1, 0, 1);
        chk("latency:lit_wl", 64'(wl_cycles), 64'd1);

        run_seq("skip_k", 18'h0FF00, 18'h00FF0, 18'h3FFFF, 32'h1111_2222, 1'b0, 0, 0, 2, 1'b0, 0, 0);
        chk("skip_k:lit_count", 64'(log_addr.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_addr.size(); i++)
            chk("skip_k:lit_addr", 64'(log_addr[i]), 64'(lit_skip[i]));

        run_seq("waitreq", 18'h2AAAA, 18'h15555, 18'h00077, 32'hCAFE_F00D, 1'b1, 3, 2, 4, 1'b0, 0, 0);

        run_seq("poll_to", 18'h00011, 18'h00022, 18'h00033, 32'h0000_0044, 1'b1, 0, -1, 0, 1'b0, 0, 0);
        chk("poll_to:lit_reads", 64'(reads_done), 64'd8);
        chk("poll_to:lit_error", {63'b0, error}, 64'd1);

        run_seq("after_fail", 18'h00055, 18'h00066, 18'h00077, 32'h0000_0088, 1'b1, 0, 0, 1, 1'b0, 0, 0);

        run_seq("lock_to", 18'h01234, 18'h04321, 18'h00010, 32'h0F0F_0F0F, 1'b1, 0, 0, -1, 1'b0, 0, 0);
        chk("lock_to:lit_wl", 64'(wl_cycles), 64'd16);

        run_seq("lock_10", 18'h01234, 18'h04321, 18'h00010, 32'h0F0F_0F0F, 1'b1, 0, 0, 10, 1'b0, 0, 0);
        chk("lock_10:lit_wl", 64'(wl_cycles), 64'd12);

        run_seq("busy_req", 18'h00A0A, 18'h0B0B0, 18'h0C0C0, 32'h1234_5678, 1'b1, 1, 1, 2, 1'b0, 1, 0);

        reset_mid;
        run_seq("restart", 18'h30A05, 18'h12010, 18'h00402, 32'h8000_1234, 1'b1, 0, 0, 3, 1'b0, 0, 0);
        chk("restart:first_addr", 64'((log_addr.size() > 0) ? log_addr[0] : -1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequences a run-time frequency change of the core PLL through its Avalon-MM reconfiguration port (the mgmt side of the PLL reconfig IP that drives reconfig_to_pll/reconfig_from_pll).
- On a request it latches a counter set, writes the registers in a fixed order and triggers the start.
- It then polls for completion, waits for PLL lock and reports done or error.
- The MemTest frequency menu uses it to step the SDRAM clock.

Parameters:
- LOCK_TIMEOUT, 1048575: clk cycles allowed for pll_locked to assert after reconfig completes; 20-bit counter.
- POLL_LIMIT, 4095: maximum status reads before declaring a poll timeout; 12-bit counter.

Ports:
- clk  in  1  management clock, also clocks the PLL reconfig IP.
- rst  in  1  asynchronous active-high reset.
- req  in  1  single-cycle start request.
- cfg_n  in  18  N counter word: hi[15:8], lo[7:0], bypass[16], odd[17].
- cfg_m  in  18  M counter word, same format as cfg_n.
- cfg_c0  in  18  C0 counter word, same format; counter select 0 is inserted by the block.
- cfg_k  in  32  fractional K value.
- cfg_k_en  in  1  1 = write K; 0 = skip the K write.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; set on poll or lock timeout, cleared by the next accepted req.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  Avalon write strobe.
- mgmt_read  out  1  Avalon read strobe.
- mgmt_writedata  out  32  write data.
- mgmt_readdata  in  32  read data.
- mgmt_waitrequest  in  1  Avalon waitrequest.
- pll_locked  in  1  PLL locked, asynchronous; the block double-flop synchronises it.

Behaviour:
- Reset: every output 0, FSM in IDLE, all latched cfg registers 0, counters 0.
- Accepting a request:
  - req is accepted only in IDLE.
  - On acceptance: all cfg_* latched, error cleared, busy set on the following cycle.
  - req while busy is ignored, with no queueing.
- Avalon rules:
  - A transfer presents address, data and strobe and holds them unchanged while mgmt_waitrequest=1.
  - A transfer completes on the edge where strobe=1 and waitrequest=0; the strobe drops the next cycle.
  - Read data is sampled in the completing cycle. This is a fixed-latency-0 slave; no readdatavalid.
  - Exactly one strobe at a time; never write and read together.
- FSM states and transfers, in order:
  - IDLE.
  - WR_MODE: addr 0, data 1 (polling mode).
  - WR_N: addr 3, data {14'b0, cfg_n}.
  - WR_M: addr 4, data {14'b0, cfg_m}.
  - WR_C: addr 5, data {9'b0, 5'd0, cfg_c0}, i.e. counter select in bits [22:18].
  - WR_K: addr 7, data cfg_k. Skipped straight to WR_START when latched cfg_k_en=0.
  - WR_START: addr 2, data 0.
  - POLL: read addr 1 repeatedly.
    - readdata[0]=1 -> WAIT_LOCK.
    - Otherwise re-issue the read on the next cycle and increment the poll counter.
    - Poll counter reaching POLL_LIMIT without bit0 -> FAIL.
  - WAIT_LOCK:
    - The lock counter starts at 0 on entry.
    - Synchronised pll_locked=1 -> DONE.
    - Counter reaching LOCK_TIMEOUT -> FAIL.
    - The lock counter increments only while locked=0.
  - DONE: done=1 for one cycle, busy=0 from the next cycle, -> IDLE.
  - FAIL: error=1 (sticky), busy=0 from the next cycle, no done pulse, -> IDLE.
- busy is high from the cycle after acceptance through the DONE/FAIL cycle inclusive.
- Latency with waitrequest=0, cfg_k_en=1, and status ready on the first read:
  - 7 transfers of one cycle each, plus 1 extra cycle between consecutive transfers.
  - Plus the 2-cycle lock synchroniser.
  - done appears no later than 20 cycles after req.
- Reset mid-sequence:
  - Strobes drop immediately (asynchronous) and the FSM returns to IDLE.
  - No completion is reported; the PLL state is undefined until the next request.
- Counters saturate and never wrap.
- The synchronised pll_locked already high on entry to WAIT_LOCK satisfies the wait immediately.

Test Plan:
- Nominal: waitrequest=0, cfg_k_en=1, status bit0=1 on the first read, locked rises 5 cycles after the start write -> writes to addr 0,3,4,5,7,2 with the correct data in that order, one read of addr 1, single done pulse, error=0.
- Skip K: cfg_k_en=0 -> no access to addr 7; WR_C is followed directly by WR_START; done is asserted.
- Waitrequest: waitrequest high for 3 cycles on each transfer -> address, data and strobe stable for 4 cycles; no duplicate writes; sequence order unchanged.
- Poll timeout: status bit0 always 0, POLL_LIMIT=8 -> exactly 8 reads, then error=1, busy=0, no done; the next req clears error.
- Lock timeout: LOCK_TIMEOUT=16, locked held 0 -> error after 16 cycles in WAIT_LOCK. A repeat run with locked rising at cycle 10 gives done.
- Reset and busy req: req pulsed while busy -> ignored, single done. rst asserted during WR_M -> all strobes 0 in the same cycle, IDLE afterwards, a new req restarts at WR_MODE.
